// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the read-return tag type used by the
// framebuffer arbiter.
package fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 3;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_CPU  = 2'd2
  } fb_tag_t;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin arbiter with a registered pointer; req[0]/gnt[0] is the
// rasterizer, req[1]/gnt[1] is the CPU.
module fb_rr_arb2
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer only moves when this arbiter actually grants, so slots taken by
  // the higher-priority requester leave the turn order untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (gnt[0]) begin
      rr_ptr <= 1'b1;
    end else if (gnt[1]) begin
      rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer SRAM arbiter: VGA scanout has absolute priority, rasterizer and
// CPU share the rest round-robin. Define FB_ARB_PERF_EN for grant/stall counters.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              ras_req,
  input  logic [ADDR_W-1:0] ras_addr,
  input  logic [DATA_W-1:0] ras_wdata,
  output logic              ras_gnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_PERF_EN
  ,
  output logic [31:0]       perf_vga_cnt,
  output logic [31:0]       perf_ras_cnt,
  output logic [31:0]       perf_cpu_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic [1:0]        rr_gnt;
  logic              arb_en;
  fb_tag_t           issue_tag;
  fb_tag_t           tag_s1;
  fb_tag_t           tag_s2;
  logic [DATA_W-1:0] vga_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  assign vga_gnt = vga_req && !rst;
  assign arb_en  = !rst && !vga_req;

  fb_rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({cpu_req, ras_req}),
    .gnt (rr_gnt)
  );

  assign ras_gnt = rr_gnt[0];
  assign cpu_gnt = rr_gnt[1];

  always_comb begin
    issue_tag = TAG_NONE;
    if (vga_gnt) begin
      issue_tag = TAG_VGA;
    end else if (cpu_gnt && !cpu_we) begin
      issue_tag = TAG_CPU;
    end
  end

  // Tag stage 2 lines up with the cycle the SRAM presents read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      tag_s1      <= TAG_NONE;
      tag_s2      <= TAG_NONE;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      mem_en <= vga_gnt || ras_gnt || cpu_gnt;
      mem_we <= ras_gnt || (cpu_gnt && cpu_we);
      if (vga_gnt) begin
        mem_addr <= vga_addr;
      end else if (ras_gnt) begin
        mem_addr  <= ras_addr;
        mem_wdata <= ras_wdata;
      end else if (cpu_gnt) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
      tag_s1 <= issue_tag;
      tag_s2 <= tag_s1;
      if (tag_s2 == TAG_VGA) begin
        vga_rdata_q <= mem_rdata;
      end
      if (tag_s2 == TAG_CPU) begin
        cpu_rdata_q <= mem_rdata;
      end
    end
  end

  assign vga_rvalid = (tag_s2 == TAG_VGA);
  assign cpu_rvalid = (tag_s2 == TAG_CPU);
  assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

`ifdef FB_ARB_PERF_EN
  // Stall means a rasterizer or CPU request was present but not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_vga_cnt   <= '0;
      perf_ras_cnt   <= '0;
      perf_cpu_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (vga_gnt) begin
        perf_vga_cnt <= perf_vga_cnt + 32'd1;
      end
      if (ras_gnt) begin
        perf_ras_cnt <= perf_ras_cnt + 32'd1;
      end
      if (cpu_gnt) begin
        perf_cpu_cnt <= perf_cpu_cnt + 32'd1;
      end
      if ((ras_req && !ras_gnt) || (cpu_req && !cpu_gnt)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: directed scenarios plus randomized traffic,
// checked against a priority/round-robin model and a shadow framebuffer.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int AW = FB_ADDR_W;
  localparam int DW = FB_DATA_W;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_gnt, vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          ras_req = 1'b0;
  logic [AW-1:0] ras_addr = '0;
  logic [DW-1:0] ras_wdata = '0;
  logic          ras_gnt;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef FB_ARB_PERF_EN
  logic [31:0]   perf_vga_cnt, perf_ras_cnt, perf_cpu_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .ras_req    (ras_req),
    .ras_addr   (ras_addr),
    .ras_wdata  (ras_wdata),
    .ras_gnt    (ras_gnt),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef FB_ARB_PERF_EN
    ,
    .perf_vga_cnt   (perf_vga_cnt),
    .perf_ras_cnt   (perf_ras_cnt),
    .perf_cpu_cnt   (perf_cpu_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Power-up framebuffer contents are a fixed function of the address.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6];
  endfunction

  // Synchronous single-port SRAM driven by the DUT's command stage.
  logic [DW-1:0] sram [0:DEPTH-1];
  bit            sram_wr [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        sram[mem_addr]    <= mem_wdata;
        sram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= sram_wr[mem_addr] ? sram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // Reference framebuffer, updated in grant order.
  logic [DW-1:0] model_mem [0:DEPTH-1];
  bit            model_wr [0:DEPTH-1];

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return model_wr[a] ? model_mem[a] : init_val(a);
  endfunction

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int            due;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            chk_wdata;
  } cmd_exp_t;

  rd_exp_t  vga_q[$];
  rd_exp_t  cpu_q[$];
  cmd_exp_t cmd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  bit prio_cpu = 1'b0;
  bit g_v = 1'b0, g_r = 1'b0, g_c = 1'b0;
  logic [DW-1:0] vga_last = '0;
  logic [DW-1:0] cpu_last = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Priority/round-robin reference; pushes expected command and read data.
  task automatic predictCycle();
    bit ev, er, ec;
    cmd_exp_t c;
    rd_exp_t  r;
    ev = 1'b0; er = 1'b0; ec = 1'b0;
    if (!rst) begin
      if (vga_req) ev = 1'b1;
      else if (ras_req && cpu_req) begin
        if (prio_cpu) ec = 1'b1; else er = 1'b1;
      end
      else if (ras_req) er = 1'b1;
      else if (cpu_req) ec = 1'b1;
    end
    checkOutput("grant{vga,ras,cpu}", longint'({vga_gnt, ras_gnt, cpu_gnt}), longint'({ev, er, ec}));
    if (er) prio_cpu = 1'b1;
    if (ec) prio_cpu = 1'b0;
    g_v = ev; g_r = er; g_c = ec;
    if (rst) return;
    c.due = cycle + 1; c.en = 1'b0; c.we = 1'b0; c.addr = '0; c.wdata = '0; c.chk_wdata = 1'b0;
    r.due = cycle + 2;
    if (ev) begin
      c.en = 1'b1; c.addr = vga_addr;
      r.data = model_read(vga_addr);
      vga_q.push_back(r);
    end else if (er) begin
      c.en = 1'b1; c.we = 1'b1; c.addr = ras_addr; c.wdata = ras_wdata; c.chk_wdata = 1'b1;
      model_mem[ras_addr] = ras_wdata;
      model_wr[ras_addr]  = 1'b1;
    end else if (ec) begin
      c.en = 1'b1; c.we = cpu_we; c.addr = cpu_addr;
      if (cpu_we) begin
        c.wdata = cpu_wdata; c.chk_wdata = 1'b1;
        model_mem[cpu_addr] = cpu_wdata;
        model_wr[cpu_addr]  = 1'b1;
      end else begin
        r.data = model_read(cpu_addr);
        cpu_q.push_back(r);
      end
    end
    cmd_q.push_back(c);
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] va,
                               input logic r, input logic [AW-1:0] ra, input logic [DW-1:0] rw,
                               input logic c, input logic cwe, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cw);
    @(posedge clk);
    #1;
    vga_req = v; vga_addr = va;
    ras_req = r; ras_addr = ra; ras_wdata = rw;
    cpu_req = c; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
    @(negedge clk);
    predictCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic checkRegsZero(input string tag);
    checkOutput({tag, " mem_en"}, longint'(mem_en), 0);
    checkOutput({tag, " mem_we"}, longint'(mem_we), 0);
    checkOutput({tag, " mem_addr"}, longint'(mem_addr), 0);
    checkOutput({tag, " mem_wdata"}, longint'(mem_wdata), 0);
    checkOutput({tag, " vga_rvalid"}, longint'(vga_rvalid), 0);
    checkOutput({tag, " cpu_rvalid"}, longint'(cpu_rvalid), 0);
    checkOutput({tag, " vga_rdata"}, longint'(vga_rdata), 0);
    checkOutput({tag, " cpu_rdata"}, longint'(cpu_rdata), 0);
  endtask

  task automatic enterReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    vga_req = 1'b0; ras_req = 1'b0; cpu_req = 1'b0;
    vga_q.delete(); cpu_q.delete(); cmd_q.delete();
    @(posedge clk);
    #1;
    checkRegsZero("reset");
    cpu_req = 1'b1; vga_req = 1'b1; ras_req = 1'b1;
    #1;
    checkOutput("gnt during rst", longint'({vga_gnt, ras_gnt, cpu_gnt}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vga_req = 1'b0; ras_req = 1'b0; cpu_req = 1'b0;
    prio_cpu = 1'b0; g_v = 1'b0; g_r = 1'b0; g_c = 1'b0;
  endtask

  // Monitor: compares command stage and read returns against the queues.
  always @(negedge clk) begin
    cmd_exp_t c;
    rd_exp_t  e;
    if (rst) begin
      vga_last = '0;
      cpu_last = '0;
    end else begin
      if (cmd_q.size() > 0 && cmd_q[0].due == cycle) begin
        c = cmd_q.pop_front();
        checkOutput("mem_en", longint'(mem_en), longint'(c.en));
        checkOutput("mem_we", longint'(mem_we), longint'(c.we));
        if (c.en) checkOutput("mem_addr", longint'(mem_addr), longint'(c.addr));
        if (c.chk_wdata) checkOutput("mem_wdata", longint'(mem_wdata), longint'(c.wdata));
      end else begin
        checkOutput("mem_en idle", longint'(mem_en), 0);
      end

      if (vga_rvalid) begin
        if (vga_q.size() == 0) begin
          checkOutput("vga_rvalid unexpected", longint'(vga_rvalid), 0);
        end else begin
          e = vga_q.pop_front();
          checkOutput("vga_rvalid cycle", longint'(cycle), longint'(e.due));
          checkOutput("vga_rdata", longint'(vga_rdata), longint'(e.data));
          vga_last = e.data;
        end
      end else begin
        checkOutput("vga_rdata hold", longint'(vga_rdata), longint'(vga_last));
        if (vga_q.size() > 0 && vga_q[0].due <= cycle) begin
          checkOutput("vga_rvalid missing", longint'(vga_rvalid), 1);
          void'(vga_q.pop_front());
        end
      end

      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) begin
          checkOutput("cpu_rvalid unexpected", longint'(cpu_rvalid), 0);
        end else begin
          e = cpu_q.pop_front();
          checkOutput("cpu_rvalid cycle", longint'(cycle), longint'(e.due));
          checkOutput("cpu_rdata", longint'(cpu_rdata), longint'(e.data));
          cpu_last = e.data;
        end
      end else begin
        checkOutput("cpu_rdata hold", longint'(cpu_rdata), longint'(cpu_last));
        if (cpu_q.size() > 0 && cpu_q[0].due <= cycle) begin
          checkOutput("cpu_rvalid missing", longint'(cpu_rvalid), 1);
          void'(cpu_q.pop_front());
        end
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    logic          rv, rr, rc, rwe;
    logic [AW-1:0] rva, rra, rca;
    logic [DW-1:0] rrw, rcw;

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    checkRegsZero("reset");
    vga_req = 1'b1; cpu_req = 1'b1;
    #1;
    checkOutput("gnt during rst", longint'({vga_gnt, ras_gnt, cpu_gnt}), 0);
    vga_req = 1'b0; cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] cpu read of preloaded address");
    applyStimulus(0, '0, 0, '0, '0, 1, 0, AW'('h0005), '0);
    idle(3);

    $display("[TB] vga priority then ras/cpu alternation");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, AW'('h40), 1, AW'('h41), 3'b001, 1, 0, AW'('h42), '0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, '0, 1, AW'('h41), 3'b110, 1, 0, AW'('h41), '0);
    idle(3);

    $display("[TB] write then read same address");
    applyStimulus(0, '0, 1, AW'('h1234), 3'b011, 0, 0, '0, '0);
    applyStimulus(0, '0, 0, '0, '0, 1, 0, AW'('h1234), '0);
    idle(3);

    $display("[TB] back-to-back reads");
    applyStimulus(1, AW'('h10), 0, '0, '0, 0, 0, '0, '0);
    applyStimulus(0, '0, 0, '0, '0, 1, 0, AW'('h20), '0);
    applyStimulus(1, AW'('h30), 0, '0, '0, 0, 0, '0, '0);
    idle(3);

    $display("[TB] reset with cpu read in flight");
    applyStimulus(0, '0, 0, '0, '0, 1, 0, AW'('h0007), '0);
    enterReset();
    idle(4);

    $display("[TB] randomized traffic");
    rv = 0; rr = 0; rc = 0; rwe = 0;
    rva = '0; rra = '0; rca = '0; rrw = '0; rcw = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!(rv && !g_v)) begin
        rv = ($urandom_range(0, 3) == 0); rva = rand_addr();
      end
      if (!(rr && !g_r)) begin
        rr = ($urandom_range(0, 1) == 0); rra = rand_addr(); rrw = DW'($urandom);
      end
      if (!(rc && !g_c)) begin
        rc = ($urandom_range(0, 1) == 0); rca = rand_addr(); rcw = DW'($urandom);
        rwe = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 31) == 0) rr = 1'b0;
      if ($urandom_range(0, 31) == 0) rc = 1'b0;
      applyStimulus(rv, rva, rr, rra, rrw, rc, rwe, rca, rcw);
    end
    idle(4);

`ifdef FB_ARB_PERF_EN
    $display("[TB] perf counters");
    enterReset();
    for (int i = 0; i < 10; i++)
      applyStimulus(1, AW'('h55), 0, '0, '0, 1, 0, AW'('h56), '0);
    applyStimulus(0, '0, 0, '0, '0, 0, 0, '0, '0);
    checkOutput("perf_vga_cnt", longint'(perf_vga_cnt), 10);
    checkOutput("perf_ras_cnt", longint'(perf_ras_cnt), 0);
    checkOutput("perf_cpu_cnt", longint'(perf_cpu_cnt), 0);
    checkOutput("perf_stall_cnt", longint'(perf_stall_cnt), 10);
    idle(3);
`endif

    checkOutput("vga_q drained", longint'(vga_q.size()), 0);
    checkOutput("cpu_q drained", longint'(cpu_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
